// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the tetris core piece-drop logic:
//   - state_e      : drop sequencer state encoding
//   - DEF_*        : default field / piece dimensions
//   - cnt_width()  : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_1_2   = 4'd2,
        S_2_3   = 4'd3,
        S_CHECK = 4'd4,
        S_WRITE = 4'd5,
        S_WAIT  = 4'd6,
        S_LOCK  = 4'd7,
        S_OVER  = 4'd8
    } state_e;

    localparam int DEF_MEM_WIDTH  = 4;
    localparam int DEF_MEM_HEIGHT = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_CELLS      = 4;

    // Bits needed to count 0..n-1; a one-value counter still gets one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collision_check.sv
// -----------------------------------------------------------------------------
// collision_check
// Combinational one-row-down test of an N-cell piece against the per-column
// height map.
// Ports:
//   coord_x  in  WIDTH*CELLS      cell columns, cell 0 in MSBs
//   coord_y  in  WIDTH*CELLS      cell rows (grow downward), cell 0 in MSBs
//   bus      in  WIDTH*MEM_WIDTH  top-occupied row per column, column 0 in MSBs
//   move_ok  out 1                every cell may drop one row
//   touch    out 1                some cell would land exactly on its column top
//   err      out 1                some cell column is outside the field
// -----------------------------------------------------------------------------
module collision_check
    import tetris_pkg::*;
#(
    parameter int MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CELLS     = DEF_CELLS
) (
    input  logic [WIDTH*CELLS-1:0]     coord_x,
    input  logic [WIDTH*CELLS-1:0]     coord_y,
    input  logic [WIDTH*MEM_WIDTH-1:0] bus,
    output logic                       move_ok,
    output logic                       touch,
    output logic                       err
);

    logic [CELLS-1:0] w_ok;
    logic [CELLS-1:0] w_touch;
    logic [CELLS-1:0] w_oor;

    // Mux-free column lookup: an out-of-range column matches no slice and
    // yields zero, so bus is never indexed past its last column.
    function automatic logic [WIDTH-1:0] column_top(
        input logic [WIDTH*MEM_WIDTH-1:0] b,
        input logic [WIDTH-1:0]           col
    );
        logic [WIDTH-1:0] t;
        t = {WIDTH{1'b0}};
        for (int c = 0; c < MEM_WIDTH; c++) begin
            t = t | ({WIDTH{32'(col) == 32'(c)}} & b[(MEM_WIDTH-1-c)*WIDTH +: WIDTH]);
        end
        return t;
    endfunction

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        logic [WIDTH-1:0] w_col;
        logic [WIDTH-1:0] w_top;
        logic [WIDTH:0]   w_nxt;
        logic             w_in;

        assign w_col = coord_x[(CELLS-1-i)*WIDTH +: WIDTH];
        // One extra bit so the bottom row + 1 cannot wrap to zero.
        assign w_nxt = {1'b0, coord_y[(CELLS-1-i)*WIDTH +: WIDTH]} + {{WIDTH{1'b0}}, 1'b1};
        assign w_in  = (32'(w_col) < 32'(MEM_WIDTH));
        assign w_top = column_top(bus, w_col);

        // An out-of-range cell can never be ok, which forces the piece blocked.
        assign w_ok[i]    = w_in && (w_nxt < {1'b0, w_top});
        assign w_touch[i] = w_in && (w_nxt == {1'b0, w_top});
        assign w_oor[i]   = !w_in;
    end

    assign move_ok = &w_ok;
    assign touch   = |w_touch;
    assign err     = |w_oor;

endmodule

// File: rtl/drop_sequencer.sv
// -----------------------------------------------------------------------------
// drop_sequencer
// Piece-drop controller: per gravity step it runs load -> launch 1_2 ->
// launch 2_3 -> check, then writes (move), waits (blocked) or locks the piece.
// A blocked first check of a fresh piece means game over.
// Ports:
//   clk, rst (async, active-low), start (honoured only when idle)
//   coord_x, coord_y, bus             check inputs, stable during S_CHECK
//   busy                              sequencer not idle
//   is_load_PC, is_load_for_launch_1_2, is_load_for_launch_2_3  load strobes
//   is_write_reg, is_write_mem        write strobes
//   is_move, is_touch, err_range      results of the last check (held)
//   is_lock                           one-cycle pulse when the piece locks
//   is_over                           game over, cleared only by reset
// All outputs are registers.
// -----------------------------------------------------------------------------
module drop_sequencer
    import tetris_pkg::*;
#(
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int MEM_HEIGHT = DEF_MEM_HEIGHT,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CELLS      = DEF_CELLS,
    parameter int GRAV_DIV   = 16,
    parameter int LOCK_TICKS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH*CELLS-1:0]     coord_x,
    input  logic [WIDTH*CELLS-1:0]     coord_y,
    input  logic [WIDTH*MEM_WIDTH-1:0] bus,
    output logic                       busy,
    output logic                       is_load_PC,
    output logic                       is_load_for_launch_1_2,
    output logic                       is_load_for_launch_2_3,
    output logic                       is_write_reg,
    output logic                       is_write_mem,
    output logic                       is_move,
    output logic                       is_touch,
    output logic                       is_lock,
    output logic                       is_over,
    output logic                       err_range
);

    localparam int LC_W = cnt_width(LOCK_TICKS);
    localparam int GC_W = cnt_width(GRAV_DIV + 1);

    // Reject degenerate configurations at elaboration.
    if (MEM_WIDTH < 1 || MEM_HEIGHT < 1 || CELLS < 1 || GRAV_DIV < 1 || LOCK_TICKS < 1) begin : g_param_check
        $error("drop_sequencer: MEM_WIDTH, MEM_HEIGHT, CELLS, GRAV_DIV and LOCK_TICKS must be >= 1");
    end

    state_e          r_state;
    state_e          w_next_state;
    logic            r_first;
    logic            w_first_nxt;
    logic [LC_W-1:0] r_lock_cnt;
    logic [LC_W-1:0] w_lock_nxt;
    logic [GC_W-1:0] r_grav_cnt;
    logic [GC_W-1:0] w_grav_nxt;

    logic w_move_ok;
    logic w_touch;
    logic w_err;

    logic r_busy;
    logic r_load_pc;
    logic r_load_1_2;
    logic r_load_2_3;
    logic r_write_reg;
    logic r_write_mem;
    logic r_move;
    logic r_touch;
    logic r_lock;
    logic r_over;
    logic r_err;

    collision_check #(
        .MEM_WIDTH (MEM_WIDTH),
        .WIDTH     (WIDTH),
        .CELLS     (CELLS)
    ) u_collision_check (
        .coord_x (coord_x),
        .coord_y (coord_y),
        .bus     (bus),
        .move_ok (w_move_ok),
        .touch   (w_touch),
        .err     (w_err)
    );

    // Next-state, first-check flag, lock counter and gravity counter.
    always_comb begin
        w_next_state = r_state;
        w_first_nxt  = r_first;
        w_lock_nxt   = r_lock_cnt;

        // Gravity counter runs only in S_WAIT, so it is zero on every entry.
        if (r_state == S_WAIT) begin
            w_grav_nxt = r_grav_cnt + {{(GC_W-1){1'b0}}, 1'b1};
        end else begin
            w_grav_nxt = {GC_W{1'b0}};
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                    w_first_nxt  = 1'b1;
                    w_lock_nxt   = {LC_W{1'b0}};
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD:  w_next_state = S_1_2;
            S_1_2:   w_next_state = S_2_3;
            S_2_3:   w_next_state = S_CHECK;
            S_CHECK: begin
                w_first_nxt = 1'b0;
                if (w_move_ok) begin
                    w_next_state = S_WRITE;
                    w_lock_nxt   = {LC_W{1'b0}};
                end else if (r_first) begin
                    // A fresh piece that cannot drop even once: field is full.
                    w_next_state = S_OVER;
                end else if (r_lock_cnt == LC_W'(LOCK_TICKS - 1)) begin
                    w_next_state = S_LOCK;
                end else begin
                    w_next_state = S_WAIT;
                    w_lock_nxt   = r_lock_cnt + {{(LC_W-1){1'b0}}, 1'b1};
                end
            end
            S_WRITE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (r_grav_cnt == GC_W'(GRAV_DIV - 1)) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_LOCK:  w_next_state = S_IDLE;
            S_OVER:  w_next_state = S_OVER;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and sequencing counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_first    <= 1'b0;
            r_lock_cnt <= {LC_W{1'b0}};
            r_grav_cnt <= {GC_W{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_first    <= w_first_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_grav_cnt <= w_grav_nxt;
        end
    end

    // Strobes decoded from the next state, so each flop mirrors a Moore
    // decode of the state register without a combinational output path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= 1'b0;
            r_load_pc   <= 1'b0;
            r_load_1_2  <= 1'b0;
            r_load_2_3  <= 1'b0;
            r_write_reg <= 1'b0;
            r_write_mem <= 1'b0;
            r_lock      <= 1'b0;
            r_over      <= 1'b0;
        end else begin
            r_busy      <= (w_next_state != S_IDLE);
            r_load_pc   <= (w_next_state == S_LOAD);
            r_load_1_2  <= (w_next_state == S_1_2);
            r_load_2_3  <= (w_next_state == S_2_3);
            r_write_reg <= (w_next_state == S_WRITE);
            r_write_mem <= (w_next_state == S_WRITE) || (w_next_state == S_LOCK);
            r_lock      <= (w_next_state == S_LOCK);
            r_over      <= (w_next_state == S_OVER);
        end
    end

    // Check results captured at the end of S_CHECK and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_move  <= 1'b0;
            r_touch <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == S_CHECK) begin
            r_move  <= w_move_ok;
            r_touch <= w_touch;
            r_err   <= w_err;
        end else begin
            r_move  <= r_move;
            r_touch <= r_touch;
            r_err   <= r_err;
        end
    end

    assign busy                   = r_busy;
    assign is_load_PC             = r_load_pc;
    assign is_load_for_launch_1_2 = r_load_1_2;
    assign is_load_for_launch_2_3 = r_load_2_3;
    assign is_write_reg           = r_write_reg;
    assign is_write_mem           = r_write_mem;
    assign is_move                = r_move;
    assign is_touch               = r_touch;
    assign is_lock                = r_lock;
    assign is_over                = r_over;
    assign err_range              = r_err;

endmodule

// File: tb/tb_drop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_drop_sequencer
// Self-checking bench: a schedule-queue reference model predicts every
// output on every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_drop_sequencer;

    localparam int MW = 4;
    localparam int MH = 4;
    localparam int W  = 8;
    localparam int NC = 4;
    localparam int GD = 4;
    localparam int LT = 2;

    // Output vector bit positions
    localparam int B_BUSY = 10, B_LPC = 9, B_L12 = 8, B_L23 = 7, B_WREG = 6, B_WMEM = 5;
    localparam int B_MOVE = 4, B_TOUCH = 3, B_LOCK = 2, B_OVER = 1, B_ERR = 0;

    // Model phases: what the sequencer is doing during a given cycle
    localparam int P_IDLE = 0, P_LOAD = 1, P_12 = 2, P_23 = 3, P_CHECK = 4;
    localparam int P_WRITE = 5, P_WAIT = 6, P_LOCK = 7, P_OVER = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W*NC-1:0] coord_x = '0;
    logic [W*NC-1:0] coord_y = '0;
    logic [W*MW-1:0] bus = '0;

    logic busy, is_load_PC, is_load_for_launch_1_2, is_load_for_launch_2_3;
    logic is_write_reg, is_write_mem, is_move, is_touch, is_lock, is_over, err_range;
    logic [10:0] out_vec;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model state
    int sched[$];
    int m_cur = P_IDLE;
    bit m_first = 1'b0;
    int m_blocked = 0;
    bit m_move = 1'b0, m_touch = 1'b0, m_err = 1'b0;

    logic [10:0] cap [0:40];

    drop_sequencer #(
        .MEM_WIDTH (MW), .MEM_HEIGHT (MH), .WIDTH (W), .CELLS (NC),
        .GRAV_DIV (GD), .LOCK_TICKS (LT)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .coord_x (coord_x), .coord_y (coord_y), .bus (bus),
        .busy (busy), .is_load_PC (is_load_PC),
        .is_load_for_launch_1_2 (is_load_for_launch_1_2),
        .is_load_for_launch_2_3 (is_load_for_launch_2_3),
        .is_write_reg (is_write_reg), .is_write_mem (is_write_mem),
        .is_move (is_move), .is_touch (is_touch), .is_lock (is_lock),
        .is_over (is_over), .err_range (err_range)
    );

    assign out_vec = {busy, is_load_PC, is_load_for_launch_1_2, is_load_for_launch_2_3,
                      is_write_reg, is_write_mem, is_move, is_touch, is_lock, is_over, err_range};

    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[7:0]};
    endfunction

    // Drop test straight from the rules: every cell must fit one row lower.
    task automatic model_check(input logic [31:0] xs, input logic [31:0] ys, input logic [31:0] bs,
                               output bit ok, output bit tch, output bit er);
        ok = 1'b1; tch = 1'b0; er = 1'b0;
        for (int i = 0; i < NC; i++) begin
            int col, nxt, top;
            col = int'(xs[(NC-1-i)*8 +: 8]);
            nxt = int'(ys[(NC-1-i)*8 +: 8]) + 1;
            if (col >= MW) begin
                er = 1'b1;
                ok = 1'b0;
            end else begin
                top = int'(bs[(MW-1-col)*8 +: 8]);
                if (nxt >= top) ok = 1'b0;
                if (nxt == top) tch = 1'b1;
            end
        end
    endtask

    task automatic push_fetch();
        sched.push_back(P_LOAD); sched.push_back(P_12);
        sched.push_back(P_23);   sched.push_back(P_CHECK);
    endtask

    task automatic push_fall();
        for (int i = 0; i < GD; i++) sched.push_back(P_WAIT);
        push_fetch();
    endtask

    function automatic logic [10:0] expected_vec();
        logic [10:0] v;
        v = 11'd0;
        v[B_BUSY]  = (m_cur != P_IDLE);
        v[B_LPC]   = (m_cur == P_LOAD);
        v[B_L12]   = (m_cur == P_12);
        v[B_L23]   = (m_cur == P_23);
        v[B_WREG]  = (m_cur == P_WRITE);
        v[B_WMEM]  = (m_cur == P_WRITE) || (m_cur == P_LOCK);
        v[B_MOVE]  = m_move;
        v[B_TOUCH] = m_touch;
        v[B_LOCK]  = (m_cur == P_LOCK);
        v[B_OVER]  = (m_cur == P_OVER);
        v[B_ERR]   = m_err;
        return v;
    endfunction

    // Reference model: advances its schedule on each clock, resets asynchronously.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_cur = P_IDLE; sched.delete();
                m_first = 1'b0; m_blocked = 0;
                m_move = 1'b0; m_touch = 1'b0; m_err = 1'b0;
            end else begin
                bit ok, tch, er;
                case (m_cur)
                    P_IDLE: if (start) begin
                        m_first = 1'b1; m_blocked = 0; push_fetch();
                    end
                    P_CHECK: begin
                        model_check(coord_x, coord_y, bus, ok, tch, er);
                        m_move = ok; m_touch = tch; m_err = er;
                        if (ok) begin
                            m_blocked = 0; sched.push_back(P_WRITE); push_fall();
                        end else if (m_first) begin
                            sched.push_back(P_OVER);
                        end else begin
                            m_blocked++;
                            if (m_blocked == LT) sched.push_back(P_LOCK);
                            else push_fall();
                        end
                        m_first = 1'b0;
                    end
                    P_OVER: sched.push_back(P_OVER);
                    default: ;
                endcase
                m_cur = (sched.size() > 0) ? sched.pop_front() : P_IDLE;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            logic [10:0] ev;
            @(negedge clk);
            cyc++;
            ev = expected_vec();
            tests++;
            if (out_vec !== ev) begin
                fails++;
                $display("FAIL outputs cycle %0d: got %b expected %b", cyc, out_vec, ev);
            end
        end
    end

    task automatic expect_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Capture outputs for cycles 1..n after a start; optionally switch rows after cycle sw.
    task automatic capture(input int n, input int sw, input logic [31:0] y_new);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            cap[k] = out_vec;
            if (k == sw) coord_y = y_new;
        end
    endtask

    // Assert reset in the middle of a cycle and check outputs drop at once.
    task automatic mid_reset(input string name);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (out_vec !== 11'd0) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, out_vec, 11'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_bit("reset_busy", busy, 1'b0);
        expect_bit("reset_over", is_over, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Free fall followed by lock
        coord_x = pack4(0, 1, 2, 3); coord_y = pack4(0, 0, 0, 0); bus = pack4(4, 4, 4, 4);
        pulse_start();
        capture(24, 12, pack4(3, 3, 3, 3));
        expect_bit("ff_load_c1",  cap[1][B_LPC], 1'b1);
        expect_bit("ff_l12_c2",   cap[2][B_L12], 1'b1);
        expect_bit("ff_l23_c3",   cap[3][B_L23], 1'b1);
        expect_bit("ff_wreg_c5",  cap[5][B_WREG], 1'b1);
        expect_bit("ff_move_c5",  cap[5][B_MOVE], 1'b1);
        expect_bit("ff_wait_c9",  cap[9][B_LPC], 1'b0);
        expect_bit("ff_load_c10", cap[10][B_LPC], 1'b1);
        expect_bit("lk_touch",    cap[14][B_TOUCH], 1'b1);
        expect_bit("lk_nomove",   cap[14][B_MOVE], 1'b0);
        expect_bit("lk_nowrite",  cap[14][B_WREG], 1'b0);
        expect_bit("lk_lock_c22", cap[22][B_LOCK], 1'b1);
        expect_bit("lk_wmem_c22", cap[22][B_WMEM], 1'b1);
        expect_bit("lk_idle_c23", cap[23][B_BUSY], 1'b0);
        expect_bit("lk_pulse_c23", cap[23][B_LOCK], 1'b0);

        // Game over: fresh piece blocked on column 1
        @(posedge clk); #1;
        coord_y = pack4(0, 0, 0, 0); bus = pack4(4, 1, 4, 4);
        pulse_start();
        capture(8, 0, 32'd0);
        expect_bit("go_over_c5",  cap[5][B_OVER], 1'b1);
        expect_bit("go_touch_c5", cap[5][B_TOUCH], 1'b1);
        expect_bit("go_busy_c8",  cap[8][B_BUSY], 1'b1);
        @(posedge clk); #1;
        pulse_start();
        pulse_start();
        capture(4, 0, 32'd0);
        expect_bit("go_sticky",   cap[4][B_OVER], 1'b1);
        expect_bit("go_noload",   cap[1][B_LPC] | cap[2][B_LPC], 1'b0);
        mid_reset("go_reset");

        // Column out of range
        coord_x = pack4(0, 1, 2, 4); bus = pack4(4, 4, 4, 4);
        pulse_start();
        capture(8, 0, 32'd0);
        expect_bit("rg_err_c5",  cap[5][B_ERR], 1'b1);
        expect_bit("rg_move_c5", cap[5][B_MOVE], 1'b0);
        expect_bit("rg_nowrite", cap[5][B_WREG] | cap[5][B_WMEM], 1'b0);
        mid_reset("rg_reset");

        // Reset during WAIT, then a fresh piece must behave as first check
        coord_x = pack4(0, 1, 2, 3);
        pulse_start();
        capture(7, 0, 32'd0);
        mid_reset("wait_reset");
        bus = pack4(4, 1, 4, 4);
        pulse_start();
        capture(6, 0, 32'd0);
        expect_bit("fresh_load", cap[1][B_LPC], 1'b1);
        expect_bit("fresh_over", cap[5][B_OVER], 1'b1);
        mid_reset("fresh_reset");

        // Randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            if ((m_cur == P_OVER && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
                rst = 1'b0;
            else
                rst = 1'b1;
            start = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NC; i++) begin
                coord_x[(NC-1-i)*8 +: 8] = ($urandom_range(0, 19) == 0) ? 8'(4 + $urandom_range(0, 3))
                                                                        : 8'($urandom_range(0, 3));
                coord_y[(NC-1-i)*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4))
                                                                       : 8'($urandom_range(0, 1));
            end
            for (int c = 0; c < MW; c++) begin
                bus[(MW-1-c)*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'd4;
            end
        end
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
